// File: rtl/lcm_reg_wr_ctl_if.sv
// Register-write bus carrying an index and a write value every clock.
// The master drives an index of 0 in any cycle that has no write.
interface lcm_reg_wr_ctl_if #(
   parameter int DATA_W = 64
) ();
   logic [7:0]        wr_reg_n;
   logic [DATA_W-1:0] wr_reg_n_value;

   modport master (output wr_reg_n, output wr_reg_n_value);
   modport slave  (input  wr_reg_n, input  wr_reg_n_value);
endinterface

// File: rtl/lcm_reg_wr_ctl.sv
// LCM local configuration register write block: decodes index/value writes into
// registered configuration levels and one-cycle command strobes.
module lcm_reg_wr_ctl #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   lcm_reg_wr_ctl_if.slave     wr,
   output logic                lcm2ssm_reset,
   output logic                lcm2ssm_rd,
   output logic [ADDR_W-1:0]   lcm2ssm_addr,
   output logic [7:0]          protocol_type,
   output logic                pgm_config_reset,
   output logic [DATA_W-1:0]   sent_start_time_n_reg_o,
   output logic [DATA_W-1:0]   sent_rate_n_reg_o,
   output logic                sent_start,
   output logic                sent_model,
   output logic [DATA_W-1:0]   sent_time_reg_o,
   output logic [DATA_W-1:0]   sent_num_reg_o,
   output logic                mux2port_0_rd
);

   localparam logic [7:0] IDX_SSM_RESET  = 8'd1;
   localparam logic [7:0] IDX_SSM_READ   = 8'd2;
   localparam logic [7:0] IDX_PROTOCOL   = 8'd3;
   localparam logic [7:0] IDX_PGM_RESET  = 8'd4;
   localparam logic [7:0] IDX_START_TIME = 8'd5;
   localparam logic [7:0] IDX_RATE       = 8'd6;
   localparam logic [7:0] IDX_START      = 8'd7;
   localparam logic [7:0] IDX_MODEL      = 8'd8;
   localparam logic [7:0] IDX_TIME       = 8'd9;
   localparam logic [7:0] IDX_NUM        = 8'd10;
   localparam logic [7:0] IDX_MUX_READ   = 8'd11;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lcm2ssm_reset           <= 1'b0;
         lcm2ssm_rd              <= 1'b0;
         lcm2ssm_addr            <= '0;
         protocol_type           <= '0;
         pgm_config_reset        <= 1'b0;
         sent_start_time_n_reg_o <= '0;
         sent_rate_n_reg_o       <= '0;
         sent_start              <= 1'b0;
         sent_model              <= 1'b0;
         sent_time_reg_o         <= '0;
         sent_num_reg_o          <= '0;
         mux2port_0_rd           <= 1'b0;
      end else begin
         // NOTE: strobes default low here so a later case arm can raise them for exactly one cycle.
         lcm2ssm_rd    <= 1'b0;
         mux2port_0_rd <= 1'b0;
         // NOTE: plain case (not unique) so an X index matches no arm and falls to default as "no write".
         case (wr.wr_reg_n)
            IDX_SSM_RESET:  lcm2ssm_reset <= wr.wr_reg_n_value[0];
            IDX_SSM_READ: begin
               lcm2ssm_addr <= wr.wr_reg_n_value[ADDR_W-1:0];
               lcm2ssm_rd   <= 1'b1;
            end
            IDX_PROTOCOL:   protocol_type           <= wr.wr_reg_n_value[7:0];
            IDX_PGM_RESET:  pgm_config_reset        <= wr.wr_reg_n_value[0];
            IDX_START_TIME: sent_start_time_n_reg_o <= wr.wr_reg_n_value;
            IDX_RATE:       sent_rate_n_reg_o       <= wr.wr_reg_n_value;
            IDX_START:      sent_start              <= wr.wr_reg_n_value[0];
            IDX_MODEL:      sent_model              <= wr.wr_reg_n_value[0];
            IDX_TIME:       sent_time_reg_o         <= wr.wr_reg_n_value;
            IDX_NUM:        sent_num_reg_o          <= wr.wr_reg_n_value;
            IDX_MUX_READ:   mux2port_0_rd           <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcm_reg_wr_ctl.sv
// Directed self-checking bench for lcm_reg_wr_ctl; each step drives one write
// and checks the registered outputs 1 ns after the following rising edge.
module tb_lcm_reg_wr_ctl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lcm2ssm_reset, lcm2ssm_rd, pgm_config_reset;
   logic        sent_start, sent_model, mux2port_0_rd;
   logic [10:0] lcm2ssm_addr;
   logic [7:0]  protocol_type;
   logic [63:0] sent_start_time_n_reg_o, sent_rate_n_reg_o;
   logic [63:0] sent_time_reg_o, sent_num_reg_o;

   int vectors     = 0;
   int miscompares = 0;

   lcm_reg_wr_ctl_if #(.DATA_W(64)) wr_if ();

   lcm_reg_wr_ctl dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .wr                      (wr_if.slave),
      .lcm2ssm_reset           (lcm2ssm_reset),
      .lcm2ssm_rd              (lcm2ssm_rd),
      .lcm2ssm_addr            (lcm2ssm_addr),
      .protocol_type           (protocol_type),
      .pgm_config_reset        (pgm_config_reset),
      .sent_start_time_n_reg_o (sent_start_time_n_reg_o),
      .sent_rate_n_reg_o       (sent_rate_n_reg_o),
      .sent_start              (sent_start),
      .sent_model              (sent_model),
      .sent_time_reg_o         (sent_time_reg_o),
      .sent_num_reg_o          (sent_num_reg_o),
      .mux2port_0_rd           (mux2port_0_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [7:0] idx, input logic [63:0] val);
      wr_if.wr_reg_n       = idx;
      wr_if.wr_reg_n_value = val;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".ssm_reset"},  64'(lcm2ssm_reset), 64'd0);
      chk({tag, ".ssm_rd"},     64'(lcm2ssm_rd), 64'd0);
      chk({tag, ".ssm_addr"},   64'(lcm2ssm_addr), 64'd0);
      chk({tag, ".protocol"},   64'(protocol_type), 64'd0);
      chk({tag, ".pgm_reset"},  64'(pgm_config_reset), 64'd0);
      chk({tag, ".start_time"}, sent_start_time_n_reg_o, 64'd0);
      chk({tag, ".rate"},       sent_rate_n_reg_o, 64'd0);
      chk({tag, ".start"},      64'(sent_start), 64'd0);
      chk({tag, ".model"},      64'(sent_model), 64'd0);
      chk({tag, ".time"},       sent_time_reg_o, 64'd0);
      chk({tag, ".num"},        sent_num_reg_o, 64'd0);
      chk({tag, ".mux_rd"},     64'(mux2port_0_rd), 64'd0);
   endtask

   initial begin
      rst_n                = 1'b0;
      wr_if.wr_reg_n       = 8'd0;
      wr_if.wr_reg_n_value = 64'd0;
      step(8'd0, 64'd0);
      rst_n = 1'b1;

      // Arbitrary writes, then reset with a write presented in the same cycle
      step(8'd1, 64'd1);
      step(8'd3, 64'h55);
      step(8'd10, 64'h1234);
      step(8'd11, 64'd0);
      chk("pre_reset.mux_rd", 64'(mux2port_0_rd), 64'd1);
      rst_n = 1'b0;
      step(8'd9, 64'd123);
      chk_all_zero("reset");
      rst_n = 1'b1;
      step(8'd0, 64'd0);
      chk_all_zero("post_reset");

      // Sequential writes: index i gets value i-1
      step(8'd1, 64'd0);
      chk("seq1.ssm_reset", 64'(lcm2ssm_reset), 64'd0);
      step(8'd2, 64'd1);
      chk("seq2.ssm_addr", 64'(lcm2ssm_addr), 64'd1);
      chk("seq2.ssm_rd", 64'(lcm2ssm_rd), 64'd1);
      step(8'd3, 64'd2);
      chk("seq3.ssm_rd", 64'(lcm2ssm_rd), 64'd0);
      chk("seq3.ssm_addr_hold", 64'(lcm2ssm_addr), 64'd1);
      chk("seq3.protocol", 64'(protocol_type), 64'd2);
      step(8'd4, 64'd3);
      chk("seq4.pgm_reset", 64'(pgm_config_reset), 64'd1);
      step(8'd5, 64'd4);
      chk("seq5.start_time", sent_start_time_n_reg_o, 64'd4);
      step(8'd6, 64'd5);
      chk("seq6.rate", sent_rate_n_reg_o, 64'd5);
      step(8'd7, 64'd6);
      chk("seq7.start", 64'(sent_start), 64'd0);
      step(8'd8, 64'd7);
      chk("seq8.model", 64'(sent_model), 64'd1);
      step(8'd9, 64'd8);
      chk("seq9.time", sent_time_reg_o, 64'd8);
      step(8'd10, 64'd9);
      chk("seq10.num", sent_num_reg_o, 64'd9);
      chk("seq10.mux_rd", 64'(mux2port_0_rd), 64'd0);
      step(8'd11, 64'd10);
      chk("seq11.mux_rd", 64'(mux2port_0_rd), 64'd1);
      step(8'd12, 64'd11);
      chk("seq12.mux_rd", 64'(mux2port_0_rd), 64'd0);
      chk("seq12.ssm_reset", 64'(lcm2ssm_reset), 64'd0);
      chk("seq12.ssm_addr", 64'(lcm2ssm_addr), 64'd1);
      chk("seq12.protocol", 64'(protocol_type), 64'd2);
      chk("seq12.pgm_reset", 64'(pgm_config_reset), 64'd1);
      chk("seq12.start_time", sent_start_time_n_reg_o, 64'd4);
      chk("seq12.rate", sent_rate_n_reg_o, 64'd5);
      chk("seq12.start", 64'(sent_start), 64'd0);
      chk("seq12.model", 64'(sent_model), 64'd1);
      chk("seq12.time", sent_time_reg_o, 64'd8);
      chk("seq12.num", sent_num_reg_o, 64'd9);

      // 64-bit integrity
      step(8'd9, 64'hDEAD_BEEF_0123_4567);
      chk("wide.time", sent_time_reg_o, 64'hDEAD_BEEF_0123_4567);
      chk("wide.num_hold", sent_num_reg_o, 64'd9);
      chk("wide.rate_hold", sent_rate_n_reg_o, 64'd5);
      step(8'd255, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("idx255.time_hold", sent_time_reg_o, 64'hDEAD_BEEF_0123_4567);
      chk("idx255.protocol_hold", 64'(protocol_type), 64'd2);

      // Truncation of unused upper value bits
      step(8'd3, 64'h1FF);
      chk("trunc.protocol", 64'(protocol_type), 64'hFF);
      step(8'd2, 64'hFFFF);
      chk("trunc.ssm_addr", 64'(lcm2ssm_addr), 64'h7FF);
      chk("trunc.ssm_rd", 64'(lcm2ssm_rd), 64'd1);
      step(8'd1, 64'h2);
      chk("trunc.ssm_reset", 64'(lcm2ssm_reset), 64'd0);
      chk("trunc.ssm_rd_drop", 64'(lcm2ssm_rd), 64'd0);
      chk("trunc.ssm_addr_hold", 64'(lcm2ssm_addr), 64'h7FF);

      // Back-to-back SSM reads with different addresses
      step(8'd2, 64'h123);
      chk("b2b.addr0", 64'(lcm2ssm_addr), 64'h123);
      chk("b2b.rd0", 64'(lcm2ssm_rd), 64'd1);
      step(8'd2, 64'h456);
      chk("b2b.addr1", 64'(lcm2ssm_addr), 64'h456);
      chk("b2b.rd1", 64'(lcm2ssm_rd), 64'd1);

      // Strobe width
      step(8'd11, 64'hABCD);
      chk("strobe.ssm_rd_low", 64'(lcm2ssm_rd), 64'd0);
      chk("strobe.cyc0", 64'(mux2port_0_rd), 64'd1);
      step(8'd11, 64'd0);
      chk("strobe.cyc1", 64'(mux2port_0_rd), 64'd1);
      step(8'd0, 64'd0);
      chk("strobe.low", 64'(mux2port_0_rd), 64'd0);

      // Hold over idle cycles, including an X index
      step(8'd7, 64'd1);
      chk("hold.start_set", 64'(sent_start), 64'd1);
      for (int i = 0; i < 20; i++) step(8'd0, 64'd0);
      chk("hold.start_after_idle", 64'(sent_start), 64'd1);
      step(8'bxxxx_xxxx, 64'd0);
      chk("xidx.start_hold", 64'(sent_start), 64'd1);
      chk("xidx.mux_rd", 64'(mux2port_0_rd), 64'd0);
      step(8'd7, 64'd0);
      chk("hold.start_clear", 64'(sent_start), 64'd0);
      chk("final.model", 64'(sent_model), 64'd1);
      chk("final.pgm_reset", 64'(pgm_config_reset), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
